// File: rtl/compute_t.sv
// compute_t: first IDCT matrix product T = S' x C for one 8x8 block.
// Loads one row of S' from DPRAM0 into a local row buffer. It then forms the
// eight dot products of that row against the columns of C, using a single
// 16x12 signed multiplier. Each scaled result is written to DPRAM1 in
// row-major order.
module compute_t #(
    parameter int         DATA_W = 16,
    parameter int         COEF_W = 12,
    parameter logic [6:0] S_BASE = 7'd64,
    parameter logic [6:0] T_BASE = 7'd0,
    parameter int         SHIFT  = 8
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        CT_start,
    output logic        CT_done,
    output logic [6:0]  DP0_read_address,
    input  logic [31:0] DP0_read_data,
    output logic [6:0]  DP1_write_address,
    output logic [31:0] DP1_write_data,
    output logic        DP1_write_enable
);

    localparam int ACC_W  = 32;
    localparam int PROD_W = DATA_W + COEF_W;

    // C[k][j], indexed by {k, j}: one row of eight coefficients per k
    localparam logic signed [COEF_W-1:0] C_TAB [0:63] = '{
        12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
        12'sd2008,  12'sd1702,  12'sd1137,  12'sd399,  -12'sd399,  -12'sd1137, -12'sd1702, -12'sd2008,
        12'sd1892,  12'sd783,  -12'sd783,  -12'sd1892, -12'sd1892, -12'sd783,   12'sd783,   12'sd1892,
        12'sd1702, -12'sd399,  -12'sd2008, -12'sd1137,  12'sd1137,  12'sd2008,  12'sd399,  -12'sd1702,
        12'sd1448, -12'sd1448, -12'sd1448,  12'sd1448,  12'sd1448, -12'sd1448, -12'sd1448,  12'sd1448,
        12'sd1137, -12'sd2008,  12'sd399,   12'sd1702, -12'sd1702, -12'sd399,   12'sd2008, -12'sd1137,
        12'sd783,  -12'sd1892,  12'sd1892, -12'sd783,  -12'sd783,   12'sd1892, -12'sd1892,  12'sd783,
        12'sd399,  -12'sd1137,  12'sd1702, -12'sd2008,  12'sd2008, -12'sd1702,  12'sd1137, -12'sd399
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_WAIT,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Floor scaling of an accumulated sum: arithmetic shift keeps the sign,
    // so negative sums round toward minus infinity rather than toward zero.
    function automatic logic signed [ACC_W-1:0] scale_sum(input logic signed [ACC_W-1:0] v);
        return v >>> SHIFT;
    endfunction

    state_t                    state_q, state_d;
    logic [2:0]                row_q, row_d;
    logic [2:0]                k_q, k_d;
    logic [2:0]                j_q, j_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  srow_q [0:7];
    logic signed [DATA_W-1:0]  srow_d [0:7];

    logic signed [PROD_W-1:0]  s_ext;
    logic signed [PROD_W-1:0]  c_ext;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   wr_data;

    // Upper half of each DPRAM0 word carries no S' information
    logic unused_rd_hi;
    assign unused_rd_hi = ^DP0_read_data[31:DATA_W];

    // Single shared multiplier: current buffered S' entry times C[k][j]
    always_comb begin
        s_ext   = PROD_W'(srow_q[k_q]);
        c_ext   = PROD_W'(C_TAB[{k_q, j_q}]);
        product = s_ext * c_ext;
    end

    // Next-state, counter, buffer and accumulator logic plus all RAM-side outputs
    always_comb begin
        state_d           = state_q;
        row_d             = row_q;
        k_d               = k_q;
        j_d               = j_q;
        acc_d             = acc_q;
        srow_d            = srow_q;
        wr_data           = '0;
        CT_done           = 1'b0;
        DP0_read_address  = '0;
        DP1_write_address = '0;
        DP1_write_enable  = 1'b0;

        case (state_q)
            IDLE: begin
                if (CT_start) begin
                    row_d   = 3'd0;
                    k_d     = 3'd0;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                DP0_read_address = S_BASE + {1'b0, row_q, k_q};
                // Read data lags its address by one cycle
                if (k_q != 3'd0) begin
                    srow_d[k_q - 3'd1] = DP0_read_data[DATA_W-1:0];
                end
                if (k_q == 3'd7) begin
                    state_d = LOAD_WAIT;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end

            LOAD_WAIT: begin
                srow_d[7] = DP0_read_data[DATA_W-1:0];
                j_d       = 3'd0;
                k_d       = 3'd0;
                state_d   = MAC;
            end

            MAC: begin
                if (k_q == 3'd0) begin
                    acc_d = ACC_W'(product);
                end else begin
                    acc_d = acc_q + ACC_W'(product);
                end
                if (k_q == 3'd7) begin
                    state_d = WRITE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end

            WRITE: begin
                wr_data           = scale_sum(acc_q);
                DP1_write_enable  = 1'b1;
                DP1_write_address = T_BASE + {1'b0, row_q, j_q};
                if (j_q != 3'd7) begin
                    j_d     = j_q + 3'd1;
                    k_d     = 3'd0;
                    state_d = MAC;
                end else if (row_q != 3'd7) begin
                    row_d   = row_q + 3'd1;
                    k_d     = 3'd0;
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end

            DONE: begin
                CT_done = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DP1_write_data = wr_data;

    // State, counters, accumulator and row buffer; async active-low reset aborts at once
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            k_q     <= 3'd0;
            j_q     <= 3'd0;
            acc_q   <= '0;
            srow_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            k_q     <= k_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            srow_q  <= srow_d;
        end
    end

endmodule

// File: tb/tb_compute_t.sv
// Bench for compute_t: DPRAM models, a reference model of T = S' x C, and
// a scoreboard of expected writes with their cycle numbers after acceptance.
module tb_compute_t;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn     = 1'b1;
    logic        CT_start   = 1'b0;
    logic        CT_done;
    logic [6:0]  DP0_read_address;
    logic [31:0] DP0_read_data;
    logic [6:0]  DP1_write_address;
    logic [31:0] DP1_write_data;
    logic        DP1_write_enable;

    compute_t dut (
        .CLOCK_50_I        (CLOCK_50_I),
        .Resetn            (Resetn),
        .CT_start          (CT_start),
        .CT_done           (CT_done),
        .DP0_read_address  (DP0_read_address),
        .DP0_read_data     (DP0_read_data),
        .DP1_write_address (DP1_write_address),
        .DP1_write_data    (DP1_write_data),
        .DP1_write_enable  (DP1_write_enable)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    logic [31:0] dp0 [0:127];
    logic [31:0] dp1 [0:127];

    // Synchronous-read DPRAM0 and write-only DPRAM1
    always @(posedge CLOCK_50_I) begin
        DP0_read_data <= dp0[DP0_read_address];
        if (DP1_write_enable) dp1[DP1_write_address] <= DP1_write_data;
    end

    int C [8][8] = '{
        '{1448, 1448, 1448, 1448, 1448, 1448, 1448, 1448},
        '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008},
        '{1892, 783, -783, -1892, -1892, -783, 783, 1892},
        '{1702, -399, -2008, -1137, 1137, 2008, 399, -1702},
        '{1448, -1448, -1448, 1448, 1448, -1448, -1448, 1448},
        '{1137, -2008, 399, 1702, -1702, -399, 2008, -1137},
        '{783, -1892, 1892, -783, -783, 1892, -1892, 783},
        '{399, -1137, 1702, -2008, 2008, -1702, 1137, -399}
    };

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t  exp_q [$];
    int   errors = 0;
    int   checks = 0;
    bit   busy   = 0;
    int   cnt    = 0;
    logic exp_done;

    // Reference: T[i][j] = floor(sum_k S'[i][k]*C[k][j] / 256), written at cycle 81i+9j+18
    task automatic push_block();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                longint  acc;
                shortint s;
                wr_t     w;
                acc = 0;
                for (int k = 0; k < 8; k++) begin
                    s   = dp0[64 + 8*i + k][15:0];
                    acc = acc + longint'(s) * longint'(C[k][j]);
                end
                w.addr = 8*i + j;
                w.data = int'(acc >>> 8);
                w.cyc  = 81*i + 9*j + 18;
                exp_q.push_back(w);
            end
        end
    endtask

    // Acceptance model: a start is taken only by an idle block, never on the edge leaving DONE
    initial forever begin
        @(posedge CLOCK_50_I);
        if (!Resetn) begin
            busy = 0;
        end else if (busy) begin
            if (cnt == 649) busy = 0;
        end else if (CT_start) begin
            busy = 1;
            cnt  = 0;
            push_block();
        end
    end

    // Monitor: compares strobes, done pulse and idle outputs against the model
    initial forever begin
        wr_t w;
        @(negedge CLOCK_50_I);
        if (!Resetn) begin
            busy = 0;
            exp_q.delete();
        end
        if (busy) cnt++;
        exp_done = (busy && cnt == 649);
        checks++;
        if (CT_done !== exp_done) begin
            errors++;
            $display("FAIL done_pulse cycle=%0d got=%b exp=%b", cnt, CT_done, exp_done);
        end
        if (DP1_write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d exp=no write", DP1_write_address, $signed(DP1_write_data));
            end else begin
                w = exp_q.pop_front();
                if (DP1_write_address !== 7'(w.addr) || DP1_write_data !== 32'(w.data) || cnt != w.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%0d cycle=%0d exp addr=%0d data=%0d cycle=%0d",
                             DP1_write_address, $signed(DP1_write_data), cnt, w.addr, w.data, w.cyc);
                end
            end
        end
        if (exp_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_writes got=%0d pending exp=0", exp_q.size());
            end
            exp_q.delete();
        end
        if (!busy) begin
            checks++;
            if (DP0_read_address !== 7'd0 || DP1_write_address !== 7'd0 ||
                DP1_write_data !== 32'd0 || DP1_write_enable !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs got rd=%0d wa=%0d wd=%0d we=%b exp all 0",
                         DP0_read_address, DP1_write_address, DP1_write_data, DP1_write_enable);
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 128; a++) dp0[a] = 32'd0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 1000 && CT_done !== 1'b1) begin
            @(negedge CLOCK_50_I);
            n++;
        end
        if (CT_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=no done exp=done within 1000 cycles");
        end
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50_I); #1 CT_start = 1'b1;
        @(negedge CLOCK_50_I); #1 CT_start = 1'b0;
    endtask

    task automatic run_block();
        pulse_start();
        wait_done();
    endtask

    initial begin
        clear_mem();
        for (int a = 0; a < 128; a++) dp1[a] = 32'd0;
        #1 Resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50_I);
        #1 Resetn = 1'b1;
        repeat (20) @(negedge CLOCK_50_I);

        // DC only
        clear_mem(); dp0[64] = 32'd64; run_block();
        // Sign and upper-bit masking
        clear_mem(); dp0[64+25] = 32'hABCDFF00; run_block();
        // Floor scaling of +1 and -1
        clear_mem(); dp0[64] = 32'd1; run_block();
        clear_mem(); dp0[64] = 32'h1234FFFF; run_block();
        // Magnitude
        clear_mem(); for (int k = 0; k < 8; k++) dp0[64+k] = 32'd32767; run_block();
        // Random blocks, whole RAM randomised
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < 128; a++) dp0[a] = $urandom();
            run_block();
        end

        // Start pulse while busy is ignored
        pulse_start();
        repeat (98) @(negedge CLOCK_50_I);
        #1 CT_start = 1'b1;
        @(negedge CLOCK_50_I); #1 CT_start = 1'b0;
        wait_done();

        // Start held through DONE: next block begins after one idle cycle
        for (int a = 0; a < 128; a++) dp0[a] = $urandom();
        @(negedge CLOCK_50_I); #1 CT_start = 1'b1;
        wait_done();
        repeat (2) @(negedge CLOCK_50_I);
        #1 CT_start = 1'b0;
        wait_done();

        // Reset mid-block aborts with no further writes or done
        pulse_start();
        repeat (298) @(negedge CLOCK_50_I);
        #1 Resetn = 1'b0;
        repeat (2) @(negedge CLOCK_50_I);
        #1 Resetn = 1'b1;
        repeat (700) @(negedge CLOCK_50_I);

        // Recovery after abort
        for (int a = 0; a < 128; a++) dp0[a] = $urandom();
        run_block();
        repeat (5) @(negedge CLOCK_50_I);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
